// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold the value WIDTH itself, not just WIDTH-1.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: shift in the next dividend bit, trial-subtract the divisor.
// Purely combinational so it can be replicated for an unrolled or pipelined variant.
module div_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH:0]   rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted  = {rem[WIDTH-1:0], dividend_bit};
    // Extra top bit of diff is the borrow out of the trial subtraction.
    diff     = {1'b0, shifted} - {2'b00, divisor};
    q_bit    = ~diff[WIDTH+1];
    rem_next = q_bit ? diff[WIDTH:0] : shifted;
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned divider, one quotient bit per clock, WIDTH+1 cycles accept-to-done.
// Single operation in flight; start is ignored while busy; divide-by-zero finishes in one cycle.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int            CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   rem_next;
  logic             q_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem          (rem),
    .dividend_bit (dq[WIDTH-1]),
    .divisor      (dvsr),
    .rem_next     (rem_next),
    .q_bit        (q_bit)
  );

  // dq starts as the dividend and fills with quotient bits as dividend bits shift out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dq          <= '0;
      dvsr        <= '0;
      rem         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dq          <= dividend;
            dvsr        <= divisor;
            rem         <= '0;
            cnt         <= CNT_INIT;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem <= rem_next;
          dq  <= {dq[WIDTH-2:0], q_bit};
          cnt <= cnt - 1'b1;
          if (cnt == CNT_LAST) begin
            state     <= DONE;
            done      <= 1'b1;
            quotient  <= {dq[WIDTH-2:0], q_bit};
            remainder <= rem_next[WIDTH-1:0];
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider at WIDTH=64: arithmetic reference model checked every cycle plus directed literals.
module tb_seq_divider;

  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: latency and results from plain arithmetic on the accepted operands.
  bit               m_busy, m_done, m_dbz, p_dbz;
  int               m_left;
  logic [WIDTH-1:0] m_q, m_r, m_a, m_b, p_q, p_r;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_busy = 0; m_done = 0; m_dbz = 0; m_left = 0;
      m_q = '0; m_r = '0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_dbz = 0;
        m_a = dividend; m_b = divisor;
        if (divisor == '0) begin
          p_q = '1; p_r = dividend; p_dbz = 1; m_left = 0;
        end else begin
          p_q = dividend / divisor; p_r = dividend % divisor; p_dbz = 0; m_left = WIDTH;
        end
        if (m_left == 0) begin
          m_done = 1; m_q = p_q; m_r = p_r; m_dbz = p_dbz;
        end
      end
    end else if (m_done) begin
      m_done = 0; m_busy = 0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1; m_q = p_q; m_r = p_r; m_dbz = p_dbz;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 128'(busy), 128'(m_busy));
      chk("done", 128'(done), 128'(m_done));
      chk("quotient", 128'(quotient), 128'(m_q));
      chk("remainder", 128'(remainder), 128'(m_r));
      chk("div_by_zero", 128'(div_by_zero), 128'(m_dbz));
      if (done && !div_by_zero) begin
        chk("invariant", 128'(quotient) * 128'(m_b) + 128'(remainder), 128'(m_a));
        chk("rem_lt_div", 128'(remainder < m_b), 128'd1);
      end
    end
  end

  task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                        input bit edbz, input int elat);
    int n;
    accept(a, b);
    n = 1;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, 128'(n), 128'(elat));
    chk({name, "_q"}, 128'(quotient), 128'(eq));
    chk({name, "_r"}, 128'(remainder), 128'(er));
    chk({name, "_dbz"}, 128'(div_by_zero), 128'(edbz));
    @(negedge clk);
    chk({name, "_idle"}, 128'(busy), 128'd0);
  endtask

  localparam logic [WIDTH-1:0] ALL1 = '1;

  initial begin
    int n, dcount, t1, t2;
    logic [WIDTH-1:0] ra, rb;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_done", 128'(done), 128'd0);
    chk("reset_q", 128'(quotient), 128'd0);
    chk("reset_r", 128'(remainder), 128'd0);
    chk("reset_dbz", 128'(div_by_zero), 128'd0);
    rst = 1'b0;

    run_op("mul_check", 64'd19481048636, 64'd162134, 64'd120154, 64'd0, 0, 65);
    run_op("mul_check_r7", 64'd19481048643, 64'd162134, 64'd120154, 64'd7, 0, 65);
    run_op("fermat", 64'd4294967295, 64'd65535, 64'd65537, 64'd0, 0, 65);
    run_op("zero_num", 64'd0, ALL1, 64'd0, 64'd0, 0, 65);
    run_op("max_max", ALL1, ALL1, 64'd1, 64'd0, 0, 65);
    run_op("small_by_max", 64'd5, ALL1, 64'd0, 64'd5, 0, 65);
    run_op("div0", 64'd1234, 64'd0, ALL1, 64'd1234, 1, 1);
    run_op("after_div0", 64'd100, 64'd7, 64'd14, 64'd2, 0, 65);

    // Starts during an operation must be dropped.
    accept(64'd1000, 64'd3);
    dcount = 0;
    for (n = 1; n <= 80; n++) begin
      if (done) dcount++;
      if (n == 10 || n == 64) begin
        start = 1'b1; dividend = 64'd50; divisor = 64'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("ignore_done_count", 128'(dcount), 128'd1);
    chk("ignore_q", 128'(quotient), 128'd333);
    chk("ignore_r", 128'(remainder), 128'd1);

    // Start held high: back-to-back accepts WIDTH+2 cycles apart.
    dividend = 64'd999; divisor = 64'd10; start = 1'b1;
    dcount = 0; t1 = 0; t2 = 0;
    for (n = 0; n < 300 && dcount < 2; n++) begin
      @(negedge clk);
      if (done) begin
        dcount++;
        if (dcount == 1) t1 = cyc; else t2 = cyc;
      end
    end
    start = 1'b0;
    chk("held_done_count", 128'(dcount), 128'd2);
    chk("held_spacing", 128'(t2 - t1), 128'd66);
    chk("held_q", 128'(quotient), 128'd99);
    repeat (3) @(negedge clk);

    // Reset in the middle of an operation.
    accept(64'd77777, 64'd77);
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_q", 128'(quotient), 128'd0);
    chk("midrst_r", 128'(remainder), 128'd0);
    dcount = 0;
    repeat (70) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("midrst_no_done", 128'(dcount), 128'd0);
    run_op("post_rst", 64'd77777, 64'd77, 64'd1010, 64'd7, 0, 65);

    // Reset and start together: reset wins.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; dividend = 64'd9; divisor = 64'd3;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", 128'(busy), 128'd0);
    @(negedge clk);
    chk("rst_start_still_idle", 128'(busy), 128'd0);

    // Random regression with divisors of varied magnitude.
    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom} >> $urandom_range(0, 40);
      rb = {$urandom, $urandom} >> $urandom_range(0, 63);
      if (i % 10 == 9) rb = '0;
      if (rb == '0)
        run_op("rand", ra, rb, ALL1, ra, 1, 1);
      else
        run_op("rand", ra, rb, ra / rb, ra % rb, 0, 65);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative radix-2 restoring unsigned divider. It is the inverse operation of the team's parameterized carry-save multiplier and is used to check multiplier products (dividend = a·b, divisor = b ⇒ quotient = a) and for general unsigned division. One quotient bit is produced per clock, so a WIDTH-bit division takes WIDTH+1 cycles from accept to result. A start/busy/done handshake accepts one operation at a time.

## Interface
- WIDTH, 64, operand width in bits (≥ 2)
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- dividend  input  WIDTH  unsigned dividend, sampled on accepted start
- divisor  input  WIDTH  unsigned divisor, sampled on accepted start
- busy  output  1  operation in progress (RUN or DONE state)
- done  output  1  one-cycle pulse; quotient/remainder valid from this cycle on
- quotient  output  WIDTH  registered result
- remainder  output  WIDTH  registered result
- div_by_zero  output  1  registered flag; divisor was 0 for the last result

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 at an edge ⇒ accept. Latch dividend into the shift register, clear the partial remainder (WIDTH+1 bits), set the iteration counter to WIDTH, and clear div_by_zero.
  - If divisor ≠ 0 ⇒ RUN.
  - If divisor = 0 ⇒ DONE directly with quotient = all ones, remainder = dividend, div_by_zero = 1.
- RUN, one step per edge:
  - shifted = {rem[WIDTH-1:0], dq[WIDTH-1]}
  - diff = shifted − {1'b0, divisor}
  - No borrow ⇒ rem = diff, new quotient bit = 1. Borrow ⇒ rem = shifted, bit = 0.
  - dq shifts left with the new bit in the LSB, then the counter decrements.
  - When the counter reaches 0 ⇒ DONE, loading quotient = dq and remainder = rem[WIDTH-1:0].
- DONE: done=1 for exactly one cycle, then IDLE.
- start while busy=1 (RUN or DONE) is ignored, with no queueing.
- quotient, remainder and div_by_zero hold their values until the next accepted start completes. They are not cleared on accept.
- Invariant on done: dividend = quotient·divisor + remainder, and remainder < divisor (divisor ≠ 0).

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, state IDLE, counter 0.
- rst=1 at any edge, including mid-RUN or in DONE, aborts the operation. Outputs take their reset values the next cycle, and no done pulse is produced.
- rst and start high at the same edge: rst wins and start is dropped.
- Accepted start sampled at edge 0 (cycle 0):
  - busy=1 in cycles 1..WIDTH+1.
  - done=1 in cycle WIDTH+1; busy=0 in cycle WIDTH+2.
- Divide-by-zero: busy=1 and done=1 in cycle 1, idle in cycle 2.
- Throughput: a start held high continuously is accepted in the cycle busy falls. That gives one operation per WIDTH+2 cycles (2 cycles for divide-by-zero).
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package div_pkg:
  - state enum {IDLE, RUN, DONE}
  - function cnt_w(WIDTH) = $clog2(WIDTH+1) for the counter width
- Sub-module div_step: combinational, parameterized by WIDTH.
  - Inputs: rem (WIDTH+1 bits), next dividend bit, divisor.
  - Outputs: new rem, quotient bit.
  - Instantiated once. A reusable step allows a future unrolled or pipelined variant.
- Top level contains the FSM, counter, shift registers and output registers.

## Test plan
- WIDTH=64. Dividend 19481048636, divisor 162134 ⇒ quotient 120154, remainder 0. done exactly at cycle 65 after accept, busy high for cycles 1..65. Repeat with dividend 19481048643 ⇒ remainder 7.
- Dividend 4294967295, divisor 65535 ⇒ quotient 65537, remainder 0. Dividend 0, divisor 18446744073709551615 ⇒ 0, 0. Dividend = divisor = 2^64−1 ⇒ quotient 1, remainder 0. Dividend 5, divisor 2^64−1 ⇒ quotient 0, remainder 5.
- Dividend 1234, divisor 0 ⇒ quotient 2^64−1, remainder 1234, div_by_zero=1, done in cycle 1. The following normal division clears div_by_zero.
- start pulsed at cycles 10 and 64 during an operation ⇒ ignored; only one done pulse and the first operands' result. start held high ⇒ back-to-back operations 66 cycles apart.
- rst asserted at cycle 30 of an operation ⇒ next cycle busy=0, all outputs 0, no done pulse. A new start then yields a correct result.
- Random regression of 10k operand pairs at WIDTH=8, 32 and 64 against a reference model (/ and %) ⇒ every result exact and the invariant holds.
